multicycle_addsub: RTL and testbench

Parametrised, multi-cycle two's-complement add/subtract unit for the execute stage. It processes a WIDTH-bit operation CHUNK bits per clock, with a ripple carry held in a register between chunks. It produces the result plus overflow, zero, sign and carry/borrow condition codes. Operands enter and results leave through valid/ready handshakes, so the unit can sit behind a stalling pipeline stage.

---
 rtl/addsub_pkg.sv | 18 +
 rtl/multicycle_addsub_chunk_adder.sv | 25 ++
 rtl/multicycle_addsub.sv | 137 +++++++++++++
 tb/tb_multicycle_addsub.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the multi-cycle add/subtract unit.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // True when the datapath can be split into whole chunks.
    function automatic bit width_ok(input int width, input int chunk);
        return (chunk >= 1) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/multicycle_addsub_chunk_adder.sv
// CHUNK-bit ripple-carry adder, reused by the multi-cycle unit on every RUN cycle.
module chunk_adder #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic c;

    // Carry ripples bit by bit from cin up to the chunk MSB.
    always_comb begin
        c   = cin;
        sum = '0;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/multicycle_addsub.sv
// Multi-cycle add/subtract unit, CHUNK bits per cycle with valid/ready handshakes.
// Define MULTICYCLE_ADDSUB_CC_EN to build the zf/sf/cf condition codes; otherwise they read 0.
module multicycle_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             of,
    output logic             zf,
    output logic             sf,
    output logic             cf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LASTIDX = IDXW'(NCHUNK - 1);

    generate
        if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
            $error("multicycle_addsub: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic             opreg;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic [CHUNK-1:0] achunk;
    logic [CHUNK-1:0] bchunk;
    logic [CHUNK-1:0] sum;
    logic             cout;
    logic             ovf;

    // Subtraction feeds the inverted b chunk; the +1 comes from the preloaded carry.
    assign achunk = areg[int'(idx) * CHUNK +: CHUNK];
    assign bchunk = breg[int'(idx) * CHUNK +: CHUNK] ^ {CHUNK{opreg}};

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_adder (
        .a    (achunk),
        .b    (bchunk),
        .cin  (carry),
        .sum  (sum),
        .cout (cout)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Overflow needs only the operand MSBs and the MSB of the final chunk sum.
    assign ovf = (((areg[WIDTH-1] ^ breg[WIDTH-1]) == (opreg == OP_SUB)) &&
                  (sum[CHUNK-1] != areg[WIDTH-1]));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            areg   <= '0;
            breg   <= '0;
            opreg  <= OP_ADD;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            of     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        areg  <= a;
                        breg  <= b;
                        opreg <= op;
                        carry <= op;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result[int'(idx) * CHUNK +: CHUNK] <= sum;
                    carry <= cout;
                    if (idx == LASTIDX) begin
                        of    <= ovf;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MULTICYCLE_ADDSUB_CC_EN
    logic zacc;

    // zacc tracks whether every chunk finished so far summed to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            zacc <= 1'b0;
            zf   <= 1'b0;
            sf   <= 1'b0;
            cf   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            zacc <= 1'b1;
        end else if (state == RUN) begin
            zacc <= zacc & (sum == '0);
            if (idx == LASTIDX) begin
                zf <= zacc & (sum == '0);
                sf <= sum[CHUNK-1];
                cf <= (opreg == OP_ADD) ? cout : ~cout;
            end
        end
    end
`else
    assign zf = 1'b0;
    assign sf = 1'b0;
    assign cf = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_addsub.sv
// Scoreboard bench for multicycle_addsub: directed corner cases, back-pressure, reset and random traffic.
module tb_multicycle_addsub;

    localparam int WIDTH  = 64;
    localparam int CHUNK  = 16;
    localparam int NCHUNK = WIDTH / CHUNK;

    localparam logic signed [WIDTH:0] MAXS = $signed({2'b00, {(WIDTH-1){1'b1}}});
    localparam logic signed [WIDTH:0] MINS = $signed({2'b11, {(WIDTH-1){1'b0}}});

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             of;
        logic             zf;
        logic             sf;
        logic             cf;
    } expect_t;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             op        = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             of, zf, sf, cf;

    expect_t sb[$];
    expect_t monExp;
    int compared   = 0;
    int mismatched = 0;
    int readyMode  = 1;

    multicycle_addsub #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .of        (of),
        .zf        (zf),
        .sf        (sf),
        .cf        (cf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: plain wide arithmetic, signed range test for overflow, unsigned compare for borrow.
    function automatic expect_t model(input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        expect_t e;
        logic [WIDTH:0] wide;
        logic signed [WIDTH:0] s;
        if (o == 1'b0) begin
            wide = {1'b0, x} + {1'b0, y};
            s    = $signed({x[WIDTH-1], x}) + $signed({y[WIDTH-1], y});
            e.cf = wide[WIDTH];
        end else begin
            wide = {1'b0, x} - {1'b0, y};
            s    = $signed({x[WIDTH-1], x}) - $signed({y[WIDTH-1], y});
            e.cf = (x < y);
        end
        e.res = wide[WIDTH-1:0];
        e.of  = (s > MAXS) || (s < MINS);
`ifdef MULTICYCLE_ADDSUB_CC_EN
        e.zf = (e.res == '0);
        e.sf = e.res[WIDTH-1];
`else
        e.zf = 1'b0;
        e.sf = 1'b0;
        e.cf = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            3:       return {1'b0, {(WIDTH-1){1'b1}}};
            4:       return WIDTH'($urandom_range(0, 3));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Consumer side: 0 = stall, 1 = always ready, 2 = random back-pressure.
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: every accepted result is checked against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checkOutput("scoreboard_nonempty", WIDTH'(sb.size() > 0), WIDTH'(1));
            if (sb.size() > 0) begin
                monExp = sb.pop_front();
                checkOutput("result", result, monExp.res);
                checkOutput("flags_of_zf_sf_cf", WIDTH'({of, zf, sf, cf}),
                            WIDTH'({monExp.of, monExp.zf, monExp.sf, monExp.cf}));
            end
        end
    end

    task automatic applyStimulus(input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", WIDTH'(in_ready), WIDTH'(1));
            return;
        end
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        @(posedge clk);
        sb.push_back(model(o, x, y));
        #1;
        in_valid = 1'b0;
        op       = 1'($urandom_range(0, 1));
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) checkOutput("drain_timeout", WIDTH'(sb.size()), WIDTH'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] snapRes;
        logic [3:0]       snapFlags;
        int               n;

        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", WIDTH'(in_ready), WIDTH'(1));
        checkOutput("reset_out_valid", WIDTH'(out_valid), WIDTH'(0));
        checkOutput("reset_result", result, '0);
        checkOutput("reset_flags", WIDTH'({of, zf, sf, cf}), WIDTH'(0));
        reset = 1'b0;

        // Carry crossing the first chunk boundary, plus latency of the first result.
        applyStimulus(1'b0, 64'h0000_0000_0000_FFFF, 64'h1);
        for (int i = 1; i <= NCHUNK; i++) begin
            @(negedge clk);
            checkOutput("latency_run_out_valid", WIDTH'(out_valid), WIDTH'(0));
        end
        @(negedge clk);
        checkOutput("latency_done_out_valid", WIDTH'(out_valid), WIDTH'(1));

        applyStimulus(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
        applyStimulus(1'b1, 64'h8000_0000_0000_0000, 64'h1);
        applyStimulus(1'b1, 64'd5, 64'd5);
        applyStimulus(1'b1, 64'd3, 64'd5);
        waitDrain();

        // Back-pressure: outputs must hold and new operands must be refused.
        readyMode = 0;
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, {$urandom, $urandom}, {$urandom, $urandom});
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_reached_done", WIDTH'(out_valid), WIDTH'(1));
        snapRes   = result;
        snapFlags = {of, zf, sf, cf};
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            op       = 1'($urandom_range(0, 1));
            a        = {$urandom, $urandom};
            b        = {$urandom, $urandom};
            @(negedge clk);
            checkOutput("bp_result_stable", result, snapRes);
            checkOutput("bp_flags_stable", WIDTH'({of, zf, sf, cf}), WIDTH'(snapFlags));
            checkOutput("bp_in_ready_low", WIDTH'(in_ready), WIDTH'(0));
            checkOutput("bp_out_valid_high", WIDTH'(out_valid), WIDTH'(1));
        end
        in_valid  = 1'b0;
        readyMode = 1;
        n = 0;
        while (!out_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("bp_release_in_ready", WIDTH'(in_ready), WIDTH'(1));
        checkOutput("bp_release_out_valid", WIDTH'(out_valid), WIDTH'(0));
        checkOutput("bp_nothing_queued", WIDTH'(sb.size()), WIDTH'(0));

        // Reset during the second RUN cycle discards the operation.
        applyStimulus(1'b0, {$urandom, $urandom}, {$urandom, $urandom});
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        checkOutput("midrun_reset_in_ready", WIDTH'(in_ready), WIDTH'(1));
        checkOutput("midrun_reset_out_valid", WIDTH'(out_valid), WIDTH'(0));
        checkOutput("midrun_reset_result", result, '0);
        reset = 1'b0;
        applyStimulus(1'b0, 64'd2, 64'd2);
        waitDrain();

        // Random traffic with random consumer stalls.
        readyMode = 2;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), pickOperand(), pickOperand());
        end
        readyMode = 1;
        waitDrain();
        checkOutput("scoreboard_empty", WIDTH'(sb.size()), WIDTH'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
